// File: rtl/inverter_pkg.sv
// rtl/inverter_pkg.sv - shared FSM state type, GF(2^4) inverse table and share-unmask helper
package inverter_pkg;

  // Checker run state; kept as plain constants so older tools see a simple 2-bit vector
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Upper bound on shares the unmask helper folds; unused upper nibbles are zero
  localparam int MAX_SHARES = 16;

  // GF(2^4) multiplicative inverse in polynomial basis x^4 + x + 1, with 0 mapped to 0
  localparam logic [3:0] INV_LUT [16] = '{
    4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
    4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8
  };

  // Recombine Boolean shares: the plain nibble is the XOR of every share
  function automatic logic [3:0] unmask_nibble(input logic [4*MAX_SHARES-1:0] shares);
    logic [3:0] acc;
    acc = 4'h0;
    for (int i = 0; i < MAX_SHARES; i++) begin
      acc = acc ^ shares[4*i +: 4];
    end
    return acc;
  endfunction

endpackage

// File: rtl/checker_delay_line.sv
// rtl/checker_delay_line.sv - LATENCY-deep shift register aligning {valid, X, expected} with the inverter output
module checker_delay_line #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [8:0] din,
  output logic [8:0] dout
);

  localparam int WIDTH = 9;

  generate
    if (LATENCY == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [LATENCY*WIDTH-1:0] pipe_q;
      logic [LATENCY*WIDTH-1:0] pipe_d;
      logic [LATENCY*WIDTH-1:0] shift_in;

      if (LATENCY == 1) begin : g_one
        assign shift_in = din;
      end else begin : g_many
        assign shift_in = {pipe_q[(LATENCY-1)*WIDTH-1:0], din};
      end

      // Advance one stage per cycle; a clear empties every stage so no stale vector compares
      always_comb begin
        pipe_d = shift_in;
        if (clr) begin
          pipe_d = '0;
        end
      end

      // Pipeline storage, emptied immediately on reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign dout = pipe_q[LATENCY*WIDTH-1 -: WIDTH];
    end
  endgenerate

endmodule

// File: rtl/inverter_checker.sv
// rtl/inverter_checker.sv - online checker for a masked GF(2^4) inverter with error count and first-fail capture
module inverter_checker
  import inverter_pkg::*;
#(
  parameter int SHARES  = 2,
  parameter int LATENCY = 2,
  parameter int ERR_W   = 8
) (
  input  logic                ClkxCI,
  input  logic                RstxCI,
  input  logic                StartxSI,
  input  logic [7:0]          NumVecxDI,
  input  logic                InValidxSI,
  input  logic [4*SHARES-1:0] _XxDI,
  input  logic [4*SHARES-1:0] _QxDI,
  output logic                BusyxSO,
  output logic                DonexSO,
  output logic                PassxSO,
  output logic [ERR_W-1:0]    ErrCntxDO,
  output logic [3:0]          FailXxDO,
  output logic [3:0]          FailQxDO
);

  localparam logic [2:0]       DRAIN_LAST = 3'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       num_vec_q, num_vec_d;
  logic [7:0]       acc_cnt_q, acc_cnt_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [3:0]       fail_x_q, fail_x_d;
  logic [3:0]       fail_q_q, fail_q_d;

  logic [4*MAX_SHARES-1:0] x_ext;
  logic [4*MAX_SHARES-1:0] q_ext;
  logic [3:0]              x_plain;
  logic [3:0]              q_plain;
  logic                    start_ok;
  logic                    accept;
  logic [8:0]              dly_in;
  logic [8:0]              dly_out;
  logic                    dly_valid;
  logic [3:0]              dly_x;
  logic [3:0]              dly_exp;
  logic                    mismatch;

  // Widen the share buses to the helper's fixed width and recombine both nibbles
  always_comb begin
    x_ext                 = '0;
    q_ext                 = '0;
    x_ext[4*SHARES-1:0]   = _XxDI;
    q_ext[4*SHARES-1:0]   = _QxDI;
    x_plain               = unmask_nibble(x_ext);
    q_plain               = unmask_nibble(q_ext);
  end

  // A start only counts when no run is in flight; a vector only counts while the run still needs one
  always_comb begin
    start_ok = StartxSI && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    accept   = (state_q == ST_RUN) && InValidxSI && (acc_cnt_q != num_vec_q);
    dly_in   = {accept, x_plain, INV_LUT[x_plain]};
  end

  checker_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk  (ClkxCI),
    .rst  (RstxCI),
    .clr  (start_ok),
    .din  (dly_in),
    .dout (dly_out)
  );

  // Compare the recombined inverter output with the expectation that travelled alongside its input
  always_comb begin
    dly_valid = dly_out[8];
    dly_x     = dly_out[7:4];
    dly_exp   = dly_out[3:0];
    mismatch  = dly_valid && (q_plain != dly_exp);
  end

  // Run sequencing: count accepted vectors, then wait out the inverter latency before reporting
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    num_vec_d   = start_ok ? NumVecxDI : num_vec_q;
    acc_cnt_d   = start_ok ? 8'd0 : (acc_cnt_q + 8'(accept));
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc_cnt_d == num_vec_q) begin
          drain_cnt_d = 3'd0;
          state_d     = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result bookkeeping: saturating error count and a one-shot capture of the first bad vector
  always_comb begin
    err_cnt_d   = err_cnt_q;
    fail_seen_d = fail_seen_q;
    fail_x_d    = fail_x_q;
    fail_q_d    = fail_q_q;
    if (start_ok) begin
      err_cnt_d   = '0;
      fail_seen_d = 1'b0;
      fail_x_d    = 4'h0;
      fail_q_d    = 4'h0;
    end else if (mismatch) begin
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (!fail_seen_q) begin
        fail_seen_d = 1'b1;
        fail_x_d    = dly_x;
        fail_q_d    = q_plain;
      end
    end
  end

  // All checker state; reset abandons any run in progress
  always_ff @(posedge ClkxCI or posedge RstxCI) begin
    if (RstxCI) begin
      state_q     <= ST_IDLE;
      num_vec_q   <= 8'd0;
      acc_cnt_q   <= 8'd0;
      drain_cnt_q <= 3'd0;
      err_cnt_q   <= '0;
      fail_seen_q <= 1'b0;
      fail_x_q    <= 4'h0;
      fail_q_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      err_cnt_q   <= err_cnt_d;
      fail_seen_q <= fail_seen_d;
      fail_x_q    <= fail_x_d;
      fail_q_q    <= fail_q_d;
    end
  end

  // Status decode straight from state so reset clears it without waiting for a clock
  always_comb begin
    BusyxSO   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    DonexSO   = (state_q == ST_DONE);
    PassxSO   = DonexSO && (err_cnt_q == '0);
    ErrCntxDO = err_cnt_q;
    FailXxDO  = fail_x_q;
    FailQxDO  = fail_q_q;
  end

endmodule

// File: tb/tb_inverter_checker.sv
// tb/tb_inverter_checker.sv - randomized self-checking bench for inverter_checker against a GF(2^4) reference
module tb_inverter_checker;

  localparam int MAXC = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, sel;
  logic [7:0] num_vec, x_bus, q_bus;
  logic       start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic       busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [3:0] fx_a, fq_a;
  logic       busy_b, done_b, pass_b;
  logic [1:0] err_b;
  logic [3:0] fx_b, fq_b;

  inverter_checker #(.SHARES(2), .LATENCY(2), .ERR_W(8)) dut_a (
    .ClkxCI(clk), .RstxCI(rst), .StartxSI(start_a), .NumVecxDI(num_vec),
    .InValidxSI(in_valid), ._XxDI(x_bus), ._QxDI(q_bus),
    .BusyxSO(busy_a), .DonexSO(done_a), .PassxSO(pass_a), .ErrCntxDO(err_a),
    .FailXxDO(fx_a), .FailQxDO(fq_a)
  );

  inverter_checker #(.SHARES(2), .LATENCY(0), .ERR_W(2)) dut_b (
    .ClkxCI(clk), .RstxCI(rst), .StartxSI(start_b), .NumVecxDI(num_vec),
    .InValidxSI(in_valid), ._XxDI(x_bus), ._QxDI(q_bus),
    .BusyxSO(busy_b), .DonexSO(done_b), .PassxSO(pass_b), .ErrCntxDO(err_b),
    .FailXxDO(fx_b), .FailQxDO(fq_b)
  );

  logic       cur_busy, cur_done, cur_pass;
  logic [7:0] cur_err;
  logic [3:0] cur_fx, cur_fq;
  always_comb begin
    cur_busy = sel ? busy_b : busy_a;
    cur_done = sel ? done_b : done_a;
    cur_pass = sel ? pass_b : pass_a;
    cur_err  = sel ? {6'b0, err_b} : err_a;
    cur_fx   = sel ? fx_b : fx_a;
    cur_fq   = sel ? fq_b : fq_a;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference field arithmetic: carry-less multiply reduced by x^4 + x + 1
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] r;
    r = 4'h0;
    for (int c = 1; c < 16; c++) if (gf_mul(a, 4'(c)) == 4'h1) r = 4'(c);
    return r;
  endfunction

  function automatic logic [7:0] mask2(input logic [3:0] v, input logic [3:0] r);
    return {r, v ^ r};
  endfunction

  // mode 0: X sweep, unmasked X; mode 1: sweep with Q stuck at 0 for X=5; mode 2: random with gaps
  task automatic run(input bit use_b, input int nv, input int mode, input int nflt, input string tag);
    logic       cv [MAXC];
    logic [3:0] cx [MAXC];
    logic [3:0] cf [MAXC];
    logic [3:0] vflt [MAXC];
    int         k, v, tot, lat, last_k, a, exp_err, maxv, t, idx;
    logic [3:0] efx, efq, qv, r;
    lat  = use_b ? 0 : 2;
    maxv = use_b ? 3 : 255;
    for (int i = 0; i < MAXC; i++) begin
      cv[i] = 1'b0; cx[i] = 4'h0; cf[i] = 4'h0; vflt[i] = 4'h0;
    end
    for (int j = 0; j < nflt; j++) begin
      do idx = $urandom_range(0, nv - 1); while (vflt[idx] != 4'h0);
      vflt[idx] = 4'($urandom_range(1, 15));
    end
    tot = nv + ((mode == 2) ? $urandom_range(0, 3) : 0);
    k = 0; v = 0; last_k = 0;
    while (v < tot) begin
      if (mode == 2 && k < MAXC - 60 && $urandom_range(0, 3) == 0) begin
        cv[k] = 1'b0;
        cx[k] = 4'($urandom);
      end else begin
        cv[k] = 1'b1;
        cx[k] = (mode == 2) ? 4'($urandom) : 4'(v % 16);
        if (v >= nv) cf[k] = 4'($urandom);
        else if (mode == 1) cf[k] = (cx[k] == 4'h5) ? gf_inv(4'h5) : 4'h0;
        else cf[k] = vflt[v];
        if (v == nv - 1) last_k = k;
        v++;
      end
      k++;
    end
    a = 0; exp_err = 0; efx = 4'h0; efq = 4'h0;
    for (int i = 0; i < k; i++) begin
      if (cv[i] && a < nv) begin
        a++;
        qv = gf_inv(cx[i]) ^ cf[i];
        if (qv != gf_inv(cx[i])) begin
          if (exp_err == 0) begin efx = cx[i]; efq = qv; end
          exp_err++;
        end
      end
    end
    if (exp_err > maxv) exp_err = maxv;

    sel = use_b; num_vec = 8'(nv); start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_run"}, 32'(cur_busy), 32'd1);
    for (int i = 0; i < k + lat; i++) begin
      r = (mode == 2) ? 4'($urandom) : 4'h0;
      in_valid = (i < k) ? cv[i] : 1'b0;
      x_bus = mask2((i < k) ? cx[i] : 4'($urandom), r);
      qv = 4'($urandom);
      if (i >= lat) begin
        if (cv[i - lat]) qv = gf_inv(cx[i - lat]) ^ cf[i - lat];
      end
      q_bus = mask2(qv, 4'($urandom));
      if (mode == 2 && i < last_k && $urandom_range(0, 7) == 0) begin
        start = 1'b1; num_vec = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0;
    t = 0;
    while (!cur_done && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_done"}, 32'(cur_done), 32'd1);
    check({tag, "_busy_end"}, 32'(cur_busy), 32'd0);
    check({tag, "_errcnt"}, 32'(cur_err), 32'(exp_err));
    check({tag, "_pass"}, 32'(cur_pass), 32'(exp_err == 0));
    check({tag, "_failx"}, 32'(cur_fx), 32'(efx));
    check({tag, "_failq"}, 32'(cur_fq), 32'(efq));
  endtask

  // Empty run: RUN for one cycle, LATENCY cycles of DRAIN, then DONE with a pass
  task automatic run_zero(input bit use_b, input string tag);
    int lat;
    lat = use_b ? 0 : 2;
    sel = use_b; num_vec = 8'd0; start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 2 + lat; t++) begin
      check({tag, "_busy"}, 32'(cur_busy), 32'(t < 2 + lat));
      check({tag, "_done"}, 32'(cur_done), 32'(t == 2 + lat));
      if (t < 2 + lat) begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_pass"}, 32'(cur_pass), 32'd1);
    check({tag, "_errcnt"}, 32'(cur_err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nf;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_vec = 8'd0;
    x_bus = 8'h00; q_bus = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_failx", 32'(fx_a), 32'd0);
    check("rst_failq", 32'(fq_a), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(1'b0, 16, 0, 0, "sweep");
    run(1'b0, 16, 1, 0, "sweep_x5");
    run(1'b1, 16, 0, 0, "sweep_lat0");
    run(1'b1, 16, 1, 0, "sweep_x5_lat0");
    run(1'b1, 12, 2, 5, "saturate");
    run_zero(1'b1, "zero_lat0");
    run_zero(1'b0, "zero_lat2");

    sel = 1'b0; num_vec = 8'd16; start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      x_bus = mask2(4'(i + 1), 4'($urandom));
      q_bus = 8'h00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_err", 32'(err_a), 32'd0);
    check("midrst_failx", 32'(fx_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_done", 32'(done_a), 32'd0);
    run(1'b0, 16, 2, 3, "after_rst");

    for (int n = 0; n < 14; n++) begin
      nv = $urandom_range(1, 40);
      nf = $urandom_range(0, 4);
      if (nf > nv) nf = nv;
      run(1'($urandom_range(0, 1)), nv, 2, nf, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
